// File: rtl/div_req_ctrl_if.sv
// Handshake bundle between M-extension decode, the divide request controller and the divider.
// The master modport is the controller's view; slave is the surrounding environment.
interface div_req_ctrl_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            div_valid;
  logic            div_ready;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_signed;
  logic            div_out_valid;
  logic [XLEN-1:0] div_quotient;
  logic [XLEN-1:0] div_remainder;

  modport master (
    input  flush, in_valid, in_op, in_src1, in_src2, out_ready,
           div_ready, div_out_valid, div_quotient, div_remainder,
    output in_ready, out_valid, out_result,
           div_valid, div_dividend, div_divisor, div_signed
  );

  modport slave (
    output flush, in_valid, in_op, in_src1, in_src2, out_ready,
           div_ready, div_out_valid, div_quotient, div_remainder,
    input  in_ready, out_valid, out_result,
           div_valid, div_dividend, div_divisor, div_signed
  );
endinterface

// File: rtl/div_req_ctrl.sv
// Requester side of the multi-cycle divider: prepares operands, resolves divide-by-zero and
// signed overflow locally, otherwise issues to the divider and holds the width-fixed result.
module div_req_ctrl #(
  parameter int XLEN = 64
) (
  input logic           clk,
  input logic           reset,
  div_req_ctrl_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]      state_q,    state_d;
  logic [2:0]      op_q,       op_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q,  divisor_d;
  logic            signed_q,   signed_d;
  logic [XLEN-1:0] result_q,   result_d;

  logic            in_signed;
  logic [XLEN-1:0] prep_a;
  logic [XLEN-1:0] prep_b;
  logic [XLEN-1:0] min_neg;
  logic            div_by_zero;
  logic            overflow;

  // W forms take the low word, extended according to the signedness of the op.
  function automatic logic [XLEN-1:0] prep_operand(input logic [XLEN-1:0] src,
                                                   input logic w, input logic sgn);
    logic [XLEN-1:0] r;
    r = src;
    if (w) r = sgn ? {{(XLEN-32){src[31]}}, src[31:0]} : {{(XLEN-32){1'b0}}, src[31:0]};
    return r;
  endfunction

  function automatic logic [XLEN-1:0] fix_width(input logic [XLEN-1:0] val, input logic w);
    return w ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
  endfunction

  always_comb begin
    in_signed   = ~bus.in_op[0];
    prep_a      = prep_operand(bus.in_src1, bus.in_op[2], in_signed);
    prep_b      = prep_operand(bus.in_src2, bus.in_op[2], in_signed);
    min_neg     = bus.in_op[2] ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_by_zero = (prep_b == '0);
    overflow    = in_signed && (prep_a == min_neg) && (prep_b == '1);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    result_d   = result_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          op_d       = bus.in_op;
          dividend_d = prep_a;
          divisor_d  = prep_b;
          signed_d   = in_signed;
          if (div_by_zero) begin
            result_d = fix_width(bus.in_op[1] ? prep_a : '1, bus.in_op[2]);
            state_d  = DONE;
          end else if (overflow) begin
            result_d = fix_width(bus.in_op[1] ? '0 : prep_a, bus.in_op[2]);
            state_d  = DONE;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      // A flush that coincides with acceptance still leaves the divider busy.
      ISSUE: begin
        if (bus.flush)          state_d = bus.div_ready ? DRAIN : IDLE;
        else if (bus.div_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end else if (bus.div_out_valid) begin
          result_d = fix_width(op_q[1] ? bus.div_remainder : bus.div_quotient, op_q[2]);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.flush || bus.out_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (!bus.flush && bus.div_out_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signed_q   <= signed_d;
      result_q   <= result_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE) && !bus.flush;
  assign bus.div_valid    = (state_q == ISSUE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_result   = result_q;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.div_signed   = signed_q;

endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed bench for div_req_ctrl: a behavioural divider answers requests, expected results
// are queued at issue time and a monitor checks every accepted output against the queue.
module tb_div_req_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  div_req_ctrl_if #(.XLEN(64)) bus ();

  div_req_ctrl #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int handshakes = 0;
  int doneCount = 0;

  logic [63:0] expQ[$];
  string       nameQ[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Divider model: answers three cycles after the handshake with a single-cycle pulse.
  bit                 pending = 0;
  bit                 hsPrev = 0;
  int                 lat = 0;
  logic [63:0]        qv, rv;
  logic signed [63:0] sa, sb;

  always @(negedge clk) begin
    bus.div_out_valid = 1'b0;
    bus.div_quotient  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.div_remainder = 64'hBEEF_DEAD_BEEF_DEAD;
    if (reset) begin
      pending = 0;
      hsPrev  = 0;
    end else begin
      if (hsPrev) checkOutput("div_valid drop", bus.div_valid, 0);
      hsPrev = 0;
      if (pending) begin
        if (lat == 0) begin
          bus.div_out_valid = 1'b1;
          bus.div_quotient  = qv;
          bus.div_remainder = rv;
          pending = 0;
        end else begin
          lat--;
        end
      end
      if (bus.div_valid && bus.div_ready) begin
        handshakes++;
        hsPrev = 1;
        if (bus.div_signed) begin
          sa = bus.div_dividend;
          sb = bus.div_divisor;
          qv = sa / sb;
          rv = sa % sb;
        end else begin
          qv = bus.div_dividend / bus.div_divisor;
          rv = bus.div_dividend % bus.div_divisor;
        end
        pending = 1;
        lat = 2;
      end
    end
  end

  // Scoreboard monitor: every accepted result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result actual=%h required=none", bus.out_result);
      end else begin
        checkOutput(nameQ.pop_front(), bus.out_result, expQ.pop_front());
      end
      doneCount++;
    end
  end

  task automatic waitDone(input string name, input int dBefore);
    int n = 0;
    while (doneCount == dBefore && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput({name, " done"}, 64'(doneCount - dBefore), 1);
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] op,
                               input logic [63:0] s1, input logic [63:0] s2,
                               input logic [63:0] exp, input bit special, input int readyDelay);
    int hsBefore;
    int dBefore;
    hsBefore = handshakes;
    dBefore  = doneCount;
    expQ.push_back(exp);
    nameQ.push_back(name);
    if (readyDelay > 0) bus.div_ready = 1'b0;
    checkOutput({name, " in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = s1;
    bus.in_src2  = s2;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    if (special) begin
      checkOutput({name, " latency"}, bus.out_valid, 1);
      checkOutput({name, " no req"}, bus.div_valid, 0);
    end else begin
      checkOutput({name, " req"}, bus.div_valid, 1);
      for (int i = 0; i < readyDelay; i++) begin
        @(posedge clk); #2;
        checkOutput({name, " hold"}, bus.div_valid, 1);
      end
      bus.div_ready = 1'b1;
    end
    waitDone(name, dBefore);
    checkOutput({name, " handshakes"}, 64'(handshakes - hsBefore), special ? 0 : 1);
  endtask

  initial begin
    int hsBefore;
    int dBefore;
    int n;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.out_ready = 1'b1;
    bus.div_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset div_valid", bus.div_valid, 0);
    checkOutput("reset out_result", bus.out_result, 0);
    checkOutput("reset div_dividend", bus.div_dividend, 0);
    checkOutput("reset div_divisor", bus.div_divisor, 0);
    checkOutput("reset div_signed", bus.div_signed, 0);
    checkOutput("reset in_ready", bus.in_ready, 1);

    applyStimulus("DIV 100/-7",    3'b000, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 0, 0);
    applyStimulus("REM 100/-7",    3'b010, 64'd100, -64'sd7, 64'd2, 0, 3);
    applyStimulus("DIVU 5/0",      3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    applyStimulus("REMU 5/0",      3'b011, 64'd5, 64'd0, 64'd5, 1, 0);
    applyStimulus("DIV ovf",       3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 1, 0);
    applyStimulus("REM ovf",       3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'd0, 1, 0);
    applyStimulus("DIVW ovf",      3'b100, 64'h1_8000_0000, 64'hFFFF_FFFF,
                  64'hFFFF_FFFF_8000_0000, 1, 0);
    applyStimulus("DIVUW",         3'b101, 64'hFFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 0, 0);
    applyStimulus("REMW -7/2",     3'b110, 64'h0000_0000_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    applyStimulus("DIVUW sext",    3'b101, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1,
                  64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    applyStimulus("DIVUW by zero", 3'b101, 64'd5, 64'hFFFF_FFFF_0000_0000,
                  64'hFFFF_FFFF_FFFF_FFFF, 1, 0);

    // Flush while waiting on the divider, then a fresh op must get its own answer.
    hsBefore = handshakes;
    bus.in_valid = 1'b1;
    bus.in_op    = 3'b000;
    bus.in_src1  = 64'd100;
    bus.in_src2  = 64'd3;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    bus.flush = 1'b1;
    @(posedge clk); #2;
    bus.flush = 1'b0;
    checkOutput("drain in_ready", bus.in_ready, 0);
    n = 0;
    while (!bus.in_ready && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("drain exit", bus.in_ready, 1);
    checkOutput("flushed handshakes", 64'(handshakes - hsBefore), 1);
    applyStimulus("REM after drain", 3'b010, 64'd100, -64'sd7, 64'd2, 0, 0);

    // Downstream stall: result and valid must hold while nothing new is accepted.
    dBefore = doneCount;
    bus.out_ready = 1'b0;
    expQ.push_back(64'd2);
    nameQ.push_back("REMU stall");
    bus.in_valid = 1'b1;
    bus.in_op    = 3'b011;
    bus.in_src1  = 64'd17;
    bus.in_src2  = 64'd5;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall out_valid", bus.out_valid, 1);
      checkOutput("stall out_result", bus.out_result, 64'd2);
      checkOutput("stall in_ready", bus.in_ready, 0);
      @(posedge clk); #2;
    end
    bus.out_ready = 1'b1;
    waitDone("REMU stall", dBefore);

    repeat (5) @(posedge clk);
    checkOutput("queue empty", 64'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
